// File: rtl/serial_tx_piso_if.sv
// Word handshake plus serial line bundle between a word producer and serial_tx_piso.
// master = producer side, slave = transmitter side.
interface serial_tx_piso_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;
  logic              tx_out;
  logic              busy_out;
  logic              done_out;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  tx_out,
    input  busy_out,
    input  done_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output tx_out,
    output busy_out,
    output done_out
  );
endinterface

// File: rtl/serial_tx_piso.sv
// Framed PISO transmitter: idle-high, start 0, DATA_W bits LSB-first, stop 1, each bit CLKS_PER_BIT clocks.
// Latency: tx_out drops at the accept edge; done_out pulses (DATA_W+2)*CLKS_PER_BIT clocks later; valid_in ignored while busy.
module serial_tx_piso #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input logic             clk,
  input logic             res,
  serial_tx_piso_if.slave bus
);
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [DIV_W-1:0]  div_q;
  logic              tx_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;

  logic [DATA_W-1:0] shift_d;
  logic [DIV_W-1:0]  div_d;
  logic              div_last;

  always_comb begin
    shift_d  = shift_q >> 1;
    div_last = (div_q == DIV_LAST);
    div_d    = div_last ? '0 : div_q + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          div_q     <= '0;
          bit_cnt_q <= '0;
          if (bus.valid_in && ready_q) begin
            shift_q <= bus.data_in;
            state_q <= START;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          div_q <= div_d;
          if (div_last) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          div_q <= div_d;
          if (div_last) begin
            if (bit_cnt_q == BIT_LAST) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              // Present the next bit from the pre-shifted value so it lines up with the shift.
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
              tx_q      <= shift_d[0];
            end
          end
        end
        STOP: begin
          div_q <= div_d;
          if (div_last) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_out    = tx_q;
  assign bus.ready_out = ready_q;
  assign bus.busy_out  = busy_q;
  assign bus.done_out  = done_q;
endmodule
